// File: rtl/cache_line_wb_sender.sv
// Cache line write-back sender: accepts one evicted line plus its address in a
// single handshake, then issues a memory write request followed by a burst of
// word beats (word 0 first) and pulses wb_done once the final beat is taken.
module cache_line_wb_sender #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [LINE_WIDTH-1:0] wb_line,
  output logic                  mem_wr_req_valid,
  input  logic                  mem_wr_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_req_addr,
  output logic [7:0]            mem_wr_req_len,
  output logic                  mem_wr_data_valid,
  input  logic                  mem_wr_data_ready,
  output logic [WORD_WIDTH-1:0] mem_wr_data,
  output logic                  mem_wr_data_last,
  output logic                  wb_done
);

  localparam int unsigned BEATS       = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int unsigned CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {StIdle, StReq, StData, StDone} state_e;

  state_e                             state;
  logic [BEATS-1:0][WORD_WIDTH-1:0]   line_buf;
  logic [ADDR_WIDTH-1:0]              addr_buf;
  logic [CNT_W-1:0]                   beat_cnt;
  logic [CNT_W-1:0]                   beat_nxt;

  // Offset bits of the incoming address are discarded by line alignment.
  logic unused_offset_bits;
  assign unused_offset_bits = ^wb_addr[OFFSET_BITS-1:0];

  assign beat_nxt        = beat_cnt + 1'b1;
  assign mem_wr_req_addr = addr_buf;
  assign mem_wr_req_len  = 8'(BEATS - 1);

  // Control FSM with registered handshake outputs; the next beat is preloaded
  // into mem_wr_data on each accept so the data path stays a simple register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= StIdle;
      line_buf          <= '0;
      addr_buf          <= '0;
      beat_cnt          <= '0;
      wb_ready          <= 1'b1;
      mem_wr_req_valid  <= 1'b0;
      mem_wr_data_valid <= 1'b0;
      mem_wr_data_last  <= 1'b0;
      mem_wr_data       <= '0;
      wb_done           <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (wb_valid) begin
            line_buf         <= wb_line;
            addr_buf         <= {wb_addr[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            beat_cnt         <= '0;
            wb_ready         <= 1'b0;
            mem_wr_req_valid <= 1'b1;
            state            <= StReq;
          end
        end
        StReq: begin
          if (mem_wr_req_ready) begin
            mem_wr_req_valid  <= 1'b0;
            mem_wr_data_valid <= 1'b1;
            mem_wr_data       <= line_buf[0];
            mem_wr_data_last  <= (LAST_BEAT == '0);
            state             <= StData;
          end
        end
        StData: begin
          if (mem_wr_data_ready) begin
            beat_cnt <= beat_nxt;
            if (mem_wr_data_last) begin
              mem_wr_data_valid <= 1'b0;
              mem_wr_data_last  <= 1'b0;
              wb_done           <= 1'b1;
              state             <= StDone;
            end else begin
              mem_wr_data      <= line_buf[beat_nxt];
              mem_wr_data_last <= (beat_nxt == LAST_BEAT);
            end
          end
        end
        StDone: begin
          wb_done  <= 1'b0;
          wb_ready <= 1'b1;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_wb_sender.sv
// Self-checking bench for cache_line_wb_sender. The reference model is simply
// "the expected beat list is the line's words in ascending order, the request
// address is the line-aligned address, done follows the last accepted beat".
module tb_cache_line_wb_sender;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wb_valid;
  logic         wb_ready;
  logic [31:0]  wb_addr;
  logic [255:0] wb_line;
  logic         mem_wr_req_valid;
  logic         mem_wr_req_ready;
  logic [31:0]  mem_wr_req_addr;
  logic [7:0]   mem_wr_req_len;
  logic         mem_wr_data_valid;
  logic         mem_wr_data_ready;
  logic [31:0]  mem_wr_data;
  logic         mem_wr_data_last;
  logic         wb_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_line_wb_sender #(
    .LINE_WIDTH(256),
    .WORD_WIDTH(32),
    .ADDR_WIDTH(32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .wb_valid         (wb_valid),
    .wb_ready         (wb_ready),
    .wb_addr          (wb_addr),
    .wb_line          (wb_line),
    .mem_wr_req_valid (mem_wr_req_valid),
    .mem_wr_req_ready (mem_wr_req_ready),
    .mem_wr_req_addr  (mem_wr_req_addr),
    .mem_wr_req_len   (mem_wr_req_len),
    .mem_wr_data_valid(mem_wr_data_valid),
    .mem_wr_data_ready(mem_wr_data_ready),
    .mem_wr_data      (mem_wr_data),
    .mem_wr_data_last (mem_wr_data_last),
    .wb_done          (wb_done)
  );

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom();
    return l;
  endfunction

  // Drives one line through the sender starting at a negedge in IDLE and checks
  // every cycle against the expected word list. mode: 0 ready always, 1 ready
  // pattern 1,0,0 repeating, 2 random. Ends at the negedge after DONE.
  task automatic drive_line(input logic [255:0] line, input logic [31:0] addr,
                            input int req_stall, input int mode, input bit scramble,
                            input bit chain, input logic [255:0] nline,
                            input logic [31:0] naddr, output int done_cyc);
    logic [31:0] exp_addr;
    logic [31:0] exp_word;
    int k = 0, stall = 0, cyc = 0, tog = 0;
    bit req_ok = 0, fin = 0, rdy;
    exp_addr = addr & ~32'h1f;
    done_cyc = -1;
    wb_valid = 1'b1; wb_line = line; wb_addr = addr;
    mem_wr_req_ready = 1'b0; mem_wr_data_ready = 1'b0;
    n_tests++;
    if (wb_ready !== 1'b1) begin
      n_fail++; $display("FAIL accept_ready: got %b want 1", wb_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (chain) begin
      wb_line = nline; wb_addr = naddr;
    end else begin
      wb_valid = 1'b0;
    end
    while (!fin && cyc < 300) begin
      cyc++;
      if (scramble) begin
        wb_line = rand_line(); wb_addr = $urandom();
      end
      n_tests++;
      if (!req_ok) begin
        if (mem_wr_req_valid !== 1'b1 || mem_wr_data_valid !== 1'b0 ||
            mem_wr_req_addr !== exp_addr || mem_wr_req_len !== 8'd7 || wb_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL req_phase: valid=%b dvalid=%b addr=%h len=%0d rdy=%b want 1 0 %h 7 0",
                   mem_wr_req_valid, mem_wr_data_valid, mem_wr_req_addr, mem_wr_req_len,
                   wb_ready, exp_addr);
        end
        if (stall >= req_stall) begin
          mem_wr_req_ready = 1'b1; req_ok = 1;
        end else begin
          stall++;
        end
      end else if (k < 8) begin
        mem_wr_req_ready = 1'b0;
        exp_word = line[32*k +: 32];
        if (mem_wr_data_valid !== 1'b1 || mem_wr_req_valid !== 1'b0 ||
            mem_wr_data !== exp_word || mem_wr_data_last !== (k == 7) || wb_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL beat%0d: dvalid=%b rvalid=%b data=%h last=%b want 1 0 %h %b",
                   k, mem_wr_data_valid, mem_wr_req_valid, mem_wr_data, mem_wr_data_last,
                   exp_word, (k == 7));
        end
        case (mode)
          0: rdy = 1'b1;
          1: rdy = (tog % 3 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        tog++;
        mem_wr_data_ready = rdy;
        if (rdy) k++;
      end else begin
        mem_wr_data_ready = 1'b0;
        if (wb_done !== 1'b1 || mem_wr_data_valid !== 1'b0 || wb_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL done_phase: done=%b dvalid=%b rdy=%b want 1 0 0",
                   wb_done, mem_wr_data_valid, wb_ready);
        end
        fin = 1; done_cyc = cyc;
      end
      if (!fin) begin
        n_tests++;
        if (wb_done !== 1'b0) begin
          n_fail++; $display("FAIL early_done: got %b want 0 at cycle %0d", wb_done, cyc);
        end
      end
      @(negedge clk);
    end
    n_tests++;
    if (!fin) begin
      n_fail++; $display("FAIL timeout: burst stuck with %0d beats, want 8", k);
    end
    if (wb_ready !== 1'b1 || wb_done !== 1'b0 || mem_wr_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL back_idle: rdy=%b done=%b rvalid=%b want 1 0 0",
               wb_ready, wb_done, mem_wr_req_valid);
    end
  endtask

  task automatic test_reset();
    logic [255:0] line;
    line = rand_line();
    rst_n = 1'b0; wb_valid = 1'b0; wb_line = '0; wb_addr = '0;
    mem_wr_req_ready = 1'b0; mem_wr_data_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (wb_ready !== 1'b1 || wb_done !== 1'b0 || mem_wr_req_valid !== 1'b0 ||
        mem_wr_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL initial_reset: rdy=%b done=%b rv=%b dv=%b want 1 0 0 0",
                         wb_ready, wb_done, mem_wr_req_valid, mem_wr_data_valid);
    end
    // Start a burst with readies high and reset after beats 0..3 are taken.
    wb_valid = 1'b1; wb_line = line; wb_addr = 32'h2000_0013;
    mem_wr_req_ready = 1'b1; mem_wr_data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wb_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_tests++;
    if (mem_wr_data_valid !== 1'b1 || mem_wr_data !== line[4*32 +: 32]) begin
      n_fail++; $display("FAIL pre_reset_beat4: dv=%b data=%h want 1 %h",
                         mem_wr_data_valid, mem_wr_data, line[4*32 +: 32]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (wb_ready !== 1'b1 || mem_wr_req_valid !== 1'b0 || mem_wr_data_valid !== 1'b0 ||
        mem_wr_data_last !== 1'b0 || wb_done !== 1'b0 || mem_wr_req_addr !== 32'h0 ||
        mem_wr_data !== 32'h0 || mem_wr_req_len !== 8'd7) begin
      n_fail++;
      $display("FAIL async_reset: rdy=%b rv=%b dv=%b last=%b done=%b addr=%h data=%h len=%0d want 1 0 0 0 0 0 0 7",
               wb_ready, mem_wr_req_valid, mem_wr_data_valid, mem_wr_data_last, wb_done,
               mem_wr_req_addr, mem_wr_data, mem_wr_req_len);
    end
    @(negedge clk);
    mem_wr_req_ready = 1'b0; mem_wr_data_ready = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if (wb_ready !== 1'b1 || wb_done !== 1'b0 || mem_wr_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL post_reset_idle: rdy=%b done=%b rv=%b want 1 0 0",
                           wb_ready, wb_done, mem_wr_req_valid);
      end
    end
  endtask

  task automatic test_basic();
    logic [255:0] line;
    int dc;
    for (int i = 0; i < 8; i++) line[32*i +: 32] = 32'h1111_1111 * (i + 1);
    drive_line(line, 32'h1000_0047, 0, 0, 0, 0, '0, '0, dc);
    n_tests++;
    if (dc !== 10) begin
      n_fail++; $display("FAIL basic_latency: done at cycle %0d after accept, want 10", dc);
    end
  endtask

  task automatic test_req_backpressure();
    int dc;
    drive_line(rand_line(), 32'hABCD_EF9F, 5, 0, 0, 0, '0, '0, dc);
    n_tests++;
    if (dc !== 15) begin
      n_fail++; $display("FAIL req_bp_latency: done at cycle %0d, want 15", dc);
    end
  endtask

  task automatic test_data_backpressure();
    int dc;
    drive_line(rand_line(), 32'h0000_1234, 0, 1, 0, 0, '0, '0, dc);
  endtask

  task automatic test_isolation();
    int dc;
    drive_line(rand_line(), $urandom(), 2, 2, 1, 0, '0, '0, dc);
  endtask

  task automatic test_back_to_back();
    logic [255:0] l1, l2;
    logic [31:0]  a1, a2;
    int dc;
    l1 = rand_line(); l2 = rand_line(); a1 = 32'h4000_0021; a2 = 32'h5000_00FF;
    drive_line(l1, a1, 0, 0, 0, 1, l2, a2, dc);
    // wb_valid is still high here, so line 2 is accepted on the next edge.
    drive_line(l2, a2, 0, 0, 0, 0, '0, '0, dc);
    n_tests++;
    if (dc !== 10) begin
      n_fail++; $display("FAIL b2b_latency: line2 done at cycle %0d, want 10", dc);
    end
  endtask

  task automatic test_random();
    int dc;
    for (int i = 0; i < 12; i++) begin
      drive_line(rand_line(), $urandom(), $urandom_range(0, 4), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), 0, '0, '0, dc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_req_backpressure();
    test_data_backpressure();
    test_isolation();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
